// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// parity mode constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // data_xor is the reduction XOR of the payload.
  function automatic logic parity_bit(input logic data_xor, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty come from
// the count, so pointers simply wrap modulo DEPTH.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !rst;
  assign do_pop  = pop && !empty && !rst;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO: start bit, LSB-first data, optional
// parity, one or two stop bits; each bit lasts CLKS_PER_BIT clocks.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          wr_en,
  output logic                          wr_rdy,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  state_t               state;
  logic [BAUD_W-1:0]    baud;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 line;
  logic                 baud_done;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign push      = wr_en && !fifo_full && !rst;
  assign pop       = (state == ST_IDLE) && !fifo_empty && !rst;
  assign wr_rdy    = !fifo_full;
  assign busy      = (state != ST_IDLE);
  assign baud_done = (baud == BAUD_LAST);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // tx is registered from the current state, so the line trails the FSM by
  // one clock; this gives the two-edge push-to-start latency.
  always_comb begin
    line = 1'b1;
    case (state)
      ST_START:  line = 1'b0;
      ST_DATA:   line = shreg[0];
      ST_PARITY: line = par_bit;
      default:   line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      tx       <= line;
      overflow <= wr_en && fifo_full;
      case (state)
        ST_IDLE: begin
          baud    <= '0;
          bit_cnt <= '0;
          if (!fifo_empty) begin
            shreg   <= head;
            par_bit <= parity_bit(^head, PARITY);
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= ST_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud  <= '0;
            shreg <= shreg >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_PARITY: begin
          if (baud_done) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= ST_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Drives four uart_tx_fifo configurations with shared stimulus and checks
// every output each cycle against a frame-schedule reference model.
module tb_uart_tx_fifo;

  localparam int CLKS  = 4;
  localparam int DEPTH = 4;
  localparam int NCFG  = 4;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       wr_en = 1'b0;
  logic [8:0] din   = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int db_of(input int g);
    return (g == 2) ? 5 : 8;
  endfunction

  function automatic int par_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int g);
    return (g == 0) ? 1 : 2;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int DB    = db_of(g);
    localparam int PAR   = par_of(g);
    localparam int STOP  = stop_of(g);
    localparam int FRAME = CLKS * (1 + DB + ((PAR != 0) ? 1 : 0) + STOP);

    logic                       tx;
    logic                       busy;
    logic                       wr_rdy;
    logic                       overflow;
    logic [$clog2(DEPTH):0]     count;

    uart_tx_fifo #(
      .CLKS_PER_BIT (CLKS),
      .DATA_BITS    (DB),
      .PARITY       (PAR),
      .STOP_BITS    (STOP),
      .FIFO_DEPTH   (DEPTH)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din[DB-1:0]),
      .wr_en    (wr_en),
      .wr_rdy   (wr_rdy),
      .tx       (tx),
      .busy     (busy),
      .count    (count),
      .overflow (overflow)
    );

    // Model: a frame popped at edge p owns the line for edges p+1..p+FRAME,
    // and the next pop may happen no earlier than edge p+FRAME+1.
    int q[$];
    int bits[$];
    int t        = 0;
    int pop_t    = 0;
    int ready_at = 0;
    bit active   = 0;
    bit armed    = 0;
    int e_tx = 1, e_busy = 0, e_cnt = 0, e_ovf = 0, e_rdy = 1;

    always @(posedge clk) begin
      int d, ones, rel;
      bit was_full;
      if (rst) begin
        q.delete();
        active   = 0;
        ready_at = 0;
        e_ovf    = 0;
        armed    = 1;
      end else begin
        was_full = (q.size() == DEPTH);
        if (q.size() > 0 && t >= ready_at) begin
          d = q.pop_front();
          bits.delete();
          bits.push_back(0);
          ones = 0;
          for (int i = 0; i < DB; i++) begin
            bits.push_back((d >> i) & 1);
            ones += (d >> i) & 1;
          end
          if (PAR == 2) bits.push_back(ones % 2);
          else if (PAR == 1) bits.push_back(1 - ones % 2);
          for (int i = 0; i < STOP; i++) bits.push_back(1);
          active   = 1;
          pop_t    = t;
          ready_at = t + FRAME + 1;
        end
        e_ovf = (wr_en && was_full) ? 1 : 0;
        if (wr_en && !was_full) q.push_back(int'(din) & ((1 << DB) - 1));
      end
      rel    = t - pop_t - 1;
      e_tx   = (active && rel >= 0 && rel < FRAME) ? bits[rel / CLKS] : 1;
      e_busy = (active && t >= pop_t && t < pop_t + FRAME) ? 1 : 0;
      e_cnt  = q.size();
      e_rdy  = (q.size() < DEPTH) ? 1 : 0;
      t++;
    end

    always @(negedge clk) begin
      if (armed) begin
        check($sformatf("cfg%0d tx t=%0d", g, t), int'(tx), e_tx);
        check($sformatf("cfg%0d busy t=%0d", g, t), int'(busy), e_busy);
        check($sformatf("cfg%0d count t=%0d", g, t), int'(count), e_cnt);
        check($sformatf("cfg%0d overflow t=%0d", g, t), int'(overflow), e_ovf);
        check($sformatf("cfg%0d wr_rdy t=%0d", g, t), int'(wr_rdy), e_rdy);
      end
    end
  end

  task automatic cyc(input bit r, input bit w, input int d);
    @(posedge clk);
    #2;
    rst   = r;
    wr_en = w;
    din   = d[8:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, int'($urandom));
  endtask

  initial begin
    int rate;

    // reset, with a push attempt that must be ignored
    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 'h77);
    cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 0);
    idle(3);

    // single frame
    cyc(1'b0, 1'b1, 'hA5);
    idle(60);
    cyc(1'b0, 1'b1, 'h00);
    idle(60);
    cyc(1'b0, 1'b1, 'hFF);
    idle(60);
    cyc(1'b0, 1'b1, 'h13);
    idle(60);

    // back-to-back frames
    cyc(1'b0, 1'b1, 'h11);
    cyc(1'b0, 1'b1, 'h22);
    cyc(1'b0, 1'b1, 'h33);
    idle(200);

    // fill the FIFO while a frame is in flight; fifth push overflows
    cyc(1'b0, 1'b1, 'h5A);
    idle(3);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 'h40 + i);
    idle(300);

    // reset in the DATA state with two bytes still queued
    cyc(1'b0, 1'b1, 'h3C);
    cyc(1'b0, 1'b1, 'hC3);
    cyc(1'b0, 1'b1, 'h96);
    idle(10);
    cyc(1'b1, 1'b0, 0);
    idle(100);

    // random traffic alternating heavy and light load, rare resets
    for (int c = 0; c < 3000; c++) begin
      rate = (((c / 250) % 2) == 0) ? 2 : 30;
      cyc($urandom_range(0, 599) == 0, $urandom_range(0, rate - 1) == 0, int'($urandom));
    end
    idle(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
